// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the write-back stage and register file.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Processor status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // Register IDs
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  // Write-back run/halt state
  typedef enum logic {RUN, HALT} wb_state_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// Memory-stage to write-back bundle: results plus the W register controls.
interface writeback_regfile_if #(
  parameter int WIDTH = 64
);
  logic             w_stall;
  logic             w_bubble;
  logic [2:0]       m_stat;
  logic [3:0]       m_icode;
  logic [3:0]       m_dstE;
  logic [3:0]       m_dstM;
  logic [WIDTH-1:0] m_valE;
  logic [WIDTH-1:0] m_valM;

  modport master (
    output w_stall, w_bubble, m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM
  );

  modport slave (
    input w_stall, w_bubble, m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM
  );
endinterface

// File: rtl/regfile_2w.sv
// 15-entry architectural register file with two write ports; port M wins a
// same-register collision so popq %rsp leaves the popped value in %rsp.
module regfile_2w
  import y86_pkg::*;
#(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_e,
  input  logic [3:0]       dst_e,
  input  logic [WIDTH-1:0] val_e,
  input  logic             we_m,
  input  logic [3:0]       dst_m,
  input  logic [WIDTH-1:0] val_m,
  output logic [WIDTH-1:0] reg_mem0,
  output logic [WIDTH-1:0] reg_mem1,
  output logic [WIDTH-1:0] reg_mem2,
  output logic [WIDTH-1:0] reg_mem3,
  output logic [WIDTH-1:0] reg_mem4,
  output logic [WIDTH-1:0] reg_mem5,
  output logic [WIDTH-1:0] reg_mem6,
  output logic [WIDTH-1:0] reg_mem7,
  output logic [WIDTH-1:0] reg_mem8,
  output logic [WIDTH-1:0] reg_mem9,
  output logic [WIDTH-1:0] reg_mem10,
  output logic [WIDTH-1:0] reg_mem11,
  output logic [WIDTH-1:0] reg_mem12,
  output logic [WIDTH-1:0] reg_mem13,
  output logic [WIDTH-1:0] reg_mem14
);

  logic [WIDTH-1:0] regs [15];

  // Register storage: M port written last so it overrides E on a collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
      end
    end else begin
      if (we_e && dst_e != RNONE) regs[dst_e] <= val_e;
      if (we_m && dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  assign reg_mem0  = regs[0];
  assign reg_mem1  = regs[1];
  assign reg_mem2  = regs[2];
  assign reg_mem3  = regs[3];
  assign reg_mem4  = regs[4];
  assign reg_mem5  = regs[5];
  assign reg_mem6  = regs[6];
  assign reg_mem7  = regs[7];
  assign reg_mem8  = regs[8];
  assign reg_mem9  = regs[9];
  assign reg_mem10 = regs[10];
  assign reg_mem11 = regs[11];
  assign reg_mem12 = regs[12];
  assign reg_mem13 = regs[13];
  assign reg_mem14 = regs[14];

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, halt FSM, retire counter and
// the architectural register file it commits into.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RSP_INIT = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  writeback_regfile_if.slave       m_bus,
  output logic [3:0]               W_icode,
  output logic [3:0]               W_dstE,
  output logic [3:0]               W_dstM,
  output logic [WIDTH-1:0]         W_valE,
  output logic [WIDTH-1:0]         W_valM,
  output logic [WIDTH-1:0]         reg_mem0,
  output logic [WIDTH-1:0]         reg_mem1,
  output logic [WIDTH-1:0]         reg_mem2,
  output logic [WIDTH-1:0]         reg_mem3,
  output logic [WIDTH-1:0]         reg_mem4,
  output logic [WIDTH-1:0]         reg_mem5,
  output logic [WIDTH-1:0]         reg_mem6,
  output logic [WIDTH-1:0]         reg_mem7,
  output logic [WIDTH-1:0]         reg_mem8,
  output logic [WIDTH-1:0]         reg_mem9,
  output logic [WIDTH-1:0]         reg_mem10,
  output logic [WIDTH-1:0]         reg_mem11,
  output logic [WIDTH-1:0]         reg_mem12,
  output logic [WIDTH-1:0]         reg_mem13,
  output logic [WIDTH-1:0]         reg_mem14,
  output logic [2:0]               stat,
  output logic                     halted,
  output logic [31:0]              retired
);

  logic [2:0]       w_stat_p0;
  logic [3:0]       w_icode_p0;
  logic [3:0]       w_dste_p0;
  logic [3:0]       w_dstm_p0;
  logic [WIDTH-1:0] w_vale_p0;
  logic [WIDTH-1:0] w_valm_p0;
  wb_state_t        state;
  logic             commit;

  // ---- Stage boundary: memory -> W register ----
  // W register load: reset/bubble insert a nop, halt or stall freezes it
  always_ff @(posedge clk) begin
    if (reset || (!halted && !m_bus.w_stall && m_bus.w_bubble)) begin
      w_stat_p0  <= S_AOK;
      w_icode_p0 <= I_NOP;
      w_dste_p0  <= RNONE;
      w_dstm_p0  <= RNONE;
      w_vale_p0  <= '0;
      w_valm_p0  <= '0;
    end else if (!halted && !m_bus.w_stall) begin
      w_stat_p0  <= m_bus.m_stat;
      w_icode_p0 <= m_bus.m_icode;
      w_dste_p0  <= m_bus.m_dstE;
      w_dstm_p0  <= m_bus.m_dstM;
      w_vale_p0  <= m_bus.m_valE;
      w_valm_p0  <= m_bus.m_valM;
    end
  end

  assign W_icode = w_icode_p0;
  assign W_dstE  = w_dste_p0;
  assign W_dstM  = w_dstm_p0;
  assign W_valE  = w_vale_p0;
  assign W_valM  = w_valm_p0;

  // ---- Stage boundary: W register -> architectural state ----
  // A stalled W is held for another cycle, so it must not commit twice
  assign commit = (state == RUN) && (w_stat_p0 == S_AOK) && !m_bus.w_stall;

  // Halt FSM and retire counter; a faulting instruction is neither committed nor counted
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      stat    <= S_AOK;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        RUN: begin
          if (w_stat_p0 != S_AOK) begin
            state  <= HALT;
            stat   <= w_stat_p0;
            halted <= 1'b1;
          end else if (commit && w_icode_p0 != I_NOP) begin
            retired <= retired + 32'd1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  regfile_2w #(
    .WIDTH    (WIDTH),
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_e      (commit),
    .dst_e     (w_dste_p0),
    .val_e     (w_vale_p0),
    .we_m      (commit),
    .dst_m     (w_dstm_p0),
    .val_m     (w_valm_p0),
    .reg_mem0  (reg_mem0),
    .reg_mem1  (reg_mem1),
    .reg_mem2  (reg_mem2),
    .reg_mem3  (reg_mem3),
    .reg_mem4  (reg_mem4),
    .reg_mem5  (reg_mem5),
    .reg_mem6  (reg_mem6),
    .reg_mem7  (reg_mem7),
    .reg_mem8  (reg_mem8),
    .reg_mem9  (reg_mem9),
    .reg_mem10 (reg_mem10),
    .reg_mem11 (reg_mem11),
    .reg_mem12 (reg_mem12),
    .reg_mem13 (reg_mem13),
    .reg_mem14 (reg_mem14)
  );

endmodule
